// File: rtl/pipeline_pkg.sv
// Shared encodings for the 5-stage MIPS pipeline: PC-select codes, NOP word,
// primary opcodes and the instruction-fetch FSM states.
package pipeline_pkg;

  localparam logic [1:0] SEL_PC_PC4    = 2'd0;
  localparam logic [1:0] SEL_PC_JUMP   = 2'd1;
  localparam logic [1:0] SEL_PC_BRANCH = 2'd2;
  localparam logic [1:0] SEL_PC_JR     = 2'd3;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic {
    FETCH_REQ  = 1'b0,
    FETCH_HELD = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: flush > load > bubble > hold.
module if_id_reg #(
  parameter logic [31:0] NOP_WORD = pipeline_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic        flush,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc4,
  output logic [31:0] ID_inst,
  output logic [31:0] ID_pc4,
  output logic        ID_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID_inst  <= NOP_WORD;
      ID_pc4   <= 32'h0;
      ID_valid <= 1'b0;
    end else if (flush) begin
      // ID_pc4 is left alone: only the instruction is killed
      ID_inst  <= NOP_WORD;
      ID_valid <= 1'b0;
    end else if (load) begin
      ID_inst  <= load_inst;
      ID_pc4   <= load_pc4;
      ID_valid <= 1'b1;
    end else if (bubble) begin
      ID_inst  <= NOP_WORD;
      ID_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, redirect handling, imem handshake, skid and IF/ID.
// Optional IF_PERF_CNT_EN adds fetch_cnt/kill_cnt performance counters.
module if_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = pipeline_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sel_pc,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] br_addr,
  input  logic [31:0] jr_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] ID_inst,
  output logic [31:0] ID_pc4,
  output logic        ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] kill_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_plus4, redir_addr, next_pc;
  logic [31:0] skid_q, pend_addr_q, id_load_inst;
  logic        pend_vld_q, redir, pc_adv, capture_skid, id_load, id_bubble;

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign redir     = (sel_pc != SEL_PC_PC4);

  always_comb begin
    case (sel_pc)
      SEL_PC_JUMP:   redir_addr = {ID_pc4[31:28], ID_inst[25:0], 2'b00};
      SEL_PC_BRANCH: redir_addr = word_align(br_addr);
      SEL_PC_JR:     redir_addr = word_align(jr_addr);
      default:       redir_addr = pc_plus4;
    endcase
  end

  // A redirect presented on the advancing edge is newer than any pending one
  assign next_pc = redir ? redir_addr : (pend_vld_q ? pend_addr_q : pc_plus4);

  always_comb begin
    state_d      = state_q;
    imem_req     = 1'b0;
    pc_adv       = 1'b0;
    capture_skid = 1'b0;
    id_load      = 1'b0;
    id_bubble    = 1'b0;
    id_load_inst = imem_rdata;
    case (state_q)
      FETCH_REQ: begin
        imem_req = !rst;
        if (imem_ready) begin
          if (!stall) begin
            id_load = 1'b1;
            pc_adv  = 1'b1;
          end else begin
            capture_skid = 1'b1;
            state_d      = FETCH_HELD;
          end
        end else if (!stall) begin
          id_bubble = 1'b1;
        end
      end
      FETCH_HELD: begin
        id_load_inst = skid_q;
        if (!stall) begin
          id_load = 1'b1;
          pc_adv  = 1'b1;
          state_d = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH_REQ;
      pc_q       <= RESET_PC;
      pend_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pc_adv) begin
        pc_q       <= next_pc;
        pend_vld_q <= 1'b0;
      end else if (redir) begin
        pend_vld_q <= 1'b1;
      end
    end
  end

  // Data-only registers; their validity is tracked by state_q / pend_vld_q
  always_ff @(posedge clk) begin
    if (capture_skid) skid_q <= imem_rdata;
    if (!pc_adv && redir) pend_addr_q <= redir_addr;
  end

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (id_load),
    .bubble   (id_bubble),
    .flush    (flush),
    .load_inst(id_load_inst),
    .load_pc4 (pc_plus4),
    .ID_inst  (ID_inst),
    .ID_pc4   (ID_pc4),
    .ID_valid (ID_valid)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'h0;
      kill_cnt  <= 32'h0;
    end else begin
      fetch_cnt <= fetch_cnt + {31'h0, imem_ready};
      kill_cnt  <= kill_cnt + {31'h0, flush & ID_valid};
    end
  end
`else
  // Performance counters not built in this configuration
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: expected fetch addresses are queued by
// the stimulus and popped by a monitor on every accepted imem request.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel_pc = 2'd0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] br_addr = 32'h0;
  logic [31:0] jr_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b1;
  logic [31:0] pc;
  logic [31:0] ID_inst;
  logic [31:0] ID_pc4;
  logic        ID_valid;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_a;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h0800_0010;
    return 32'hC000_0000 | a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .sel_pc    (sel_pc),
    .flush     (flush),
    .stall     (stall),
    .br_addr   (br_addr),
    .jr_addr   (jr_addr),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .pc        (pc),
    .ID_inst   (ID_inst),
    .ID_pc4    (ID_pc4),
    .ID_valid  (ID_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    exp_q.push_back(a);
    step();
  endtask

  always @(negedge clk) begin
    if (!rst && imem_req && imem_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL fetch_addr: unexpected fetch at %h, none expected", imem_addr);
      end else begin
        exp_a = exp_q.pop_front();
        if (imem_addr !== exp_a) begin
          failures++;
          $display("FAIL fetch_addr: got %h expected %h", imem_addr, exp_a);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'h0, ID_valid}, 32'h0);
    check("rst_inst", ID_inst, 32'h0);
    check("rst_pc4", ID_pc4, 32'h0);
    rst = 1'b0;

    // sequential fetch
    fetch(32'h0);
    check("seq_pc4_0", ID_pc4, 32'h4);
    check("seq_valid", {31'h0, ID_valid}, 32'h1);
    check("seq_inst_0", ID_inst, 32'hC000_0000);
    fetch(32'h4);
    check("seq_pc4_1", ID_pc4, 32'h8);
    fetch(32'h8);
    check("seq_pc4_2", ID_pc4, 32'hC);
    fetch(32'hC);
    check("jmp_inst", ID_inst, 32'h0800_0010);
    check("seq_pc", pc, 32'h10);

    // jump with flush of the wrong-path word
    sel_pc = 2'd1;
    flush  = 1'b1;
    fetch(32'h10);
    sel_pc = 2'd0;
    flush  = 1'b0;
    check("flush_valid", {31'h0, ID_valid}, 32'h0);
    check("flush_inst", ID_inst, 32'h0);
    check("jump_pc", pc, 32'h40);
    fetch(32'h40);
    check("jump_inst", ID_inst, 32'hC000_0040);
    check("jump_pc4", ID_pc4, 32'h44);

    // JR with unaligned source
    sel_pc  = 2'd3;
    jr_addr = 32'h22;
    fetch(32'h44);
    sel_pc = 2'd0;
    check("jr_pc", pc, 32'h20);
    check("jr_pc4", ID_pc4, 32'h48);

    // memory wait: three bubbles
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_addr", imem_addr, 32'h20);
      check("wait_req", {31'h0, imem_req}, 32'h1);
      check("wait_valid", {31'h0, ID_valid}, 32'h0);
    end
    imem_ready = 1'b1;
    fetch(32'h20);
    check("wait_inst", ID_inst, 32'hC000_0020);
    check("wait_valid_after", {31'h0, ID_valid}, 32'h1);
    check("wait_pc", pc, 32'h24);
    fetch(32'h24);
    fetch(32'h28);
    fetch(32'h2C);
    check("pre_stall_pc", pc, 32'h30);

    // ready & stall -> skid, HELD
    stall = 1'b1;
    fetch(32'h30);
    check("held_req", {31'h0, imem_req}, 32'h0);
    check("held_pc", pc, 32'h30);
    check("held_pc4", ID_pc4, 32'h30);
    step();
    check("held_req2", {31'h0, imem_req}, 32'h0);
    stall = 1'b0;
    step();
    check("skid_inst", ID_inst, 32'hC000_0030);
    check("skid_pc4", ID_pc4, 32'h34);
    check("skid_valid", {31'h0, ID_valid}, 32'h1);
    check("skid_pc", pc, 32'h34);

    // branch redirect while waiting on memory
    imem_ready = 1'b0;
    sel_pc     = 2'd2;
    br_addr    = 32'h103;
    step();
    sel_pc = 2'd0;
    check("pend_pc_frozen", pc, 32'h34);
    check("pend_bubble", {31'h0, ID_valid}, 32'h0);
    step();
    check("pend_addr_hold", imem_addr, 32'h34);
    imem_ready = 1'b1;
    fetch(32'h34);
    check("pend_pc", pc, 32'h100);
    check("pend_inst", ID_inst, 32'hC000_0034);
    fetch(32'h100);
    check("br_pc4", ID_pc4, 32'h104);

    // async reset mid-wait with a pending redirect
    sel_pc  = 2'd3;
    jr_addr = 32'h44;
    fetch(32'h104);
    sel_pc = 2'd0;
    check("pre_rst_pc", pc, 32'h44);
    imem_ready = 1'b0;
    sel_pc     = 2'd2;
    br_addr    = 32'h200;
    step();
    sel_pc = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_valid", {31'h0, ID_valid}, 32'h0);
    check("arst_req", {31'h0, imem_req}, 32'h0);
    step();
    rst        = 1'b0;
    imem_ready = 1'b1;
    fetch(32'h0);
    check("post_rst_pc", pc, 32'h4);
    check("post_rst_pc4", ID_pc4, 32'h4);
    imem_ready = 1'b0;
    step();
    check("queue_empty", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
